// File: rtl/gpio_access_arbiter_if.sv
// Requester handshake and register-block strobe bundle for gpio_access_arbiter.
// slave: the arbiter's view. master: the environment (requesters plus register block).
interface gpio_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              gpio_en;
  logic              gpio_wr;
  logic [ADDR_W-1:0] gpio_addr;
  logic [DATA_W-1:0] gpio_wdata;
  logic [DATA_W-1:0] gpio_rdata;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, gpio_rdata,
    output ack0, ack1, err, rdata, gpio_en, gpio_wr, gpio_addr, gpio_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, gpio_rdata,
    input  ack0, ack1, err, rdata, gpio_en, gpio_wr, gpio_addr, gpio_wdata
  );
endinterface

// File: rtl/gpio_access_arbiter.sv
// Two-requester round-robin arbiter in front of one GPIO register block (one access in flight).
// Define GPIO_ARB_ADDR_CHECK_EN to reject illegal offsets with an ack+err pulse instead of forwarding.
module gpio_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  gpio_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q;
  logic              grant_q;
  logic              last_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err_q;
  logic              gpio_en_q;
  logic              gpio_wr_q;
  logic [ADDR_W-1:0] gpio_addr_q;
  logic [DATA_W-1:0] gpio_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_d;
  logic              wr_d;
  logic              legal_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_d = ~last_q;
    end else if (bus.req1) begin
      grant_d = 1'b1;
    end
    wr_d    = grant_d ? bus.wr1    : bus.wr0;
    addr_d  = grant_d ? bus.addr1  : bus.addr0;
    wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
  end

`ifdef GPIO_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_DATA = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_DIR  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFF_IN   = ADDR_W'(8'h08);

  // The input register is read-only; writes may only target data and direction.
  assign legal_d = wr_d ? (addr_d == OFF_DATA || addr_d == OFF_DIR)
                        : (addr_d == OFF_DATA || addr_d == OFF_DIR || addr_d == OFF_IN);
`else
  assign legal_d = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      gpio_en_q    <= 1'b0;
      gpio_wr_q    <= 1'b0;
      gpio_addr_q  <= '0;
      gpio_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant_q <= grant_d;
            if (legal_d) begin
              gpio_en_q    <= 1'b1;
              gpio_wr_q    <= wr_d;
              gpio_addr_q  <= addr_d;
              gpio_wdata_q <= wdata_d;
              state_q      <= ISSUE;
            end else begin
              ack0_q  <= ~grant_d;
              ack1_q  <= grant_d;
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ISSUE: begin
          gpio_en_q <= 1'b0;
          if (gpio_wr_q) begin
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // The register block presents read data one cycle after the strobe.
          rdata_q <= bus.gpio_rdata;
          ack0_q  <= ~grant_q;
          ack1_q  <= grant_q;
          state_q <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.gpio_en    = gpio_en_q;
  assign bus.gpio_wr    = gpio_wr_q;
  assign bus.gpio_addr  = gpio_addr_q;
  assign bus.gpio_wdata = gpio_wdata_q;
endmodule
